serial_addsub_ctrl: RTL and testbench

//  Bit-serial sequencer for the 1-bit add_sub cell (ports a, b, cin, en, sum, diff, carry, burrow).

---
 rtl/serial_addsub_ctrl.sv | 173 +++++++++++++++++
 tb/tb_serial_addsub_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// serial_addsub_ctrl
//
// Bit-serial sequencer for one shared combinational 1-bit add_sub cell.
// It latches two WIDTH-bit operands and an add/sub select. It then feeds the
// cell one bit pair per clock, LSB first, and keeps the carry/borrow in a
// register between clocks. The WIDTH-bit result is built up bit by bit.
// When the last bit is done, the final carry/borrow goes to cout and done
// pulses for one cycle.
//
// Ports
//   clk          rising-edge clock, sole clock domain
//   rst          synchronous reset, active-high
//   start        request, accepted only while idle
//   op           1 = add (a+b), 0 = subtract (a-b); also drives cell_en
//   a, b         operands, sampled on an accepted start
//   busy         high while a run is in progress or completing
//   done         one-cycle pulse; result/cout are valid from here on
//   result       a+b or a-b mod 2^WIDTH, held until the next accepted start
//   cout         final carry (add) or borrow (sub), held with result
//   cell_a/b     operand bits to the cell
//   cell_cin     carry-in / borrow-in to the cell
//   cell_en      add/sub select to the cell
//   cell_sum, cell_diff, cell_carry, cell_burrow   cell outputs
// ---------------------------------------------------------------------------
module serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             cell_a,
    output logic             cell_b,
    output logic             cell_cin,
    output logic             cell_en,
    input  logic             cell_sum,
    input  logic             cell_diff,
    input  logic             cell_carry,
    input  logic             cell_burrow
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             op_reg;
    logic             c_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [WIDTH-1:0] result_reg;
    logic             cout_reg;

    logic             accept;
    logic             running;
    logic             last_bit;
    logic             cell_bit;
    logic             cell_c;

    assign accept   = (state_reg == IDLE) && start;
    assign running  = (state_reg == RUN);
    assign last_bit = (idx_reg == LAST_IDX);

    // The cell computes both add and subtract outputs. op_reg picks the one
    // that belongs to the current operation.
    assign cell_bit = op_reg ? cell_sum   : cell_diff;
    assign cell_c   = op_reg ? cell_carry : cell_burrow;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Cell inputs are forced to 0 outside RUN. This keeps the shared cell
    // quiet while no run is in progress.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        cell_a   = 1'b0;
        cell_b   = 1'b0;
        cell_cin = 1'b0;
        cell_en  = 1'b0;
        case (state_reg)
            RUN: begin
                busy     = 1'b1;
                cell_a   = a_reg[idx_reg];
                cell_b   = b_reg[idx_reg];
                cell_cin = c_reg;
                cell_en  = op_reg;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- Operand / carry / index datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            op_reg   <= 1'b0;
            c_reg    <= 1'b0;
            idx_reg  <= '0;
            cout_reg <= 1'b0;
        end else if (accept) begin
            a_reg   <= a;
            b_reg   <= b;
            op_reg  <= op;
            c_reg   <= 1'b0;     // cin starts at 0 for both add and subtract
            idx_reg <= '0;
        end else if (running) begin
            c_reg   <= cell_c;
            idx_reg <= idx_reg + 1'b1;
            if (last_bit) begin
                cout_reg <= cell_c;
            end
        end
    end

    // ---------------- Result bits, written in place ----------------
    // Each result bit has its own write enable, decoded from the bit index.
    // Bits keep their value outside RUN. The result therefore stays stable
    // after done until the next run overwrites it bit by bit.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_result_bit
            always_ff @(posedge clk) begin
                if (rst) begin
                    result_reg[gi] <= 1'b0;
                end else if (running && (idx_reg == IDX_W'(gi))) begin
                    result_reg[gi] <= cell_bit;
                end
            end
        end
    endgenerate

    assign result = result_reg;
    assign cout   = cout_reg;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub_ctrl
//
// Directed bench for serial_addsub_ctrl with WIDTH=8. A behavioural 1-bit
// add_sub cell is modelled with continuous assigns. The stimulus pushes the
// hand-computed {cout, result} for each request into a queue. The monitor
// pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_serial_addsub_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         cell_a;
    logic         cell_b;
    logic         cell_cin;
    logic         cell_en;
    logic         cell_sum;
    logic         cell_diff;
    logic         cell_carry;
    logic         cell_burrow;

    int n_checks = 0;
    int n_fail   = 0;
    int done_count = 0;

    logic [W:0] exp_q[$];

    always #5 clk = ~clk;

    // Behavioural add_sub cell: full adder and full subtractor
    assign cell_sum    = cell_a ^ cell_b ^ cell_cin;
    assign cell_carry  = (cell_a & cell_b) | (cell_cin & (cell_a ^ cell_b));
    assign cell_diff   = cell_a ^ cell_b ^ cell_cin;
    assign cell_burrow = (~cell_a & cell_b) | (cell_cin & ~(cell_a ^ cell_b));

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .cout        (cout),
        .cell_a      (cell_a),
        .cell_b      (cell_b),
        .cell_cin    (cell_cin),
        .cell_en     (cell_en),
        .cell_sum    (cell_sum),
        .cell_diff   (cell_diff),
        .cell_carry  (cell_carry),
        .cell_burrow (cell_burrow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard: compares on each done pulse
    always @(negedge clk) begin
        if (done === 1'b1) begin
            logic [W:0] e;
            done_count++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: result=%0h cout=%0b with no request pending",
                         result, cout);
            end else begin
                e = exp_q.pop_front();
                chk("result", {24'd0, result}, {24'd0, e[W-1:0]});
                chk("cout", {31'd0, cout}, {31'd0, e[W]});
                $display("done: result=%02h cout=%0b (expected %02h/%0b)",
                         result, cout, e[W-1:0], e[W]);
            end
        end
    end

    // One request. Checks the done latency, the busy duration and that done
    // lasts a single cycle. With inject=1 a second start with other operands
    // is pulsed 3 cycles into the run.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic top,
                         input logic [W-1:0] er, input logic ec, input bit inject);
        int k;
        int busy_n;
        bit seen;
        @(posedge clk); #1;
        a = ta; b = tb_v; op = top; start = 1'b1;
        exp_q.push_back({ec, er});
        @(posedge clk); #1;                 // accept edge N
        start = 1'b0;
        busy_n = busy ? 1 : 0;
        k = 0;
        seen = 1'b0;
        while (k < 40 && !seen) begin
            @(posedge clk); #1;
            k++;
            if (busy) busy_n++;
            if (done) seen = 1'b1;
            if (inject && k == 3) begin
                start = 1'b1; a = 8'h11; b = 8'h22; op = ~top;
            end
            if (inject && k == 4) start = 1'b0;
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        chk("latency", k, W);
        chk("busy_cycles", busy_n, W + 1);
        @(posedge clk); #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("busy_after", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int dc0;
        int k;
        int n;
        int t[3];

        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_cell_en", {31'd0, cell_en}, 32'd0);
        rst = 1'b0;

        // 1-3: add and subtract vectors
        do_op(8'h5A, 8'h3C, 1'b1, 8'h96, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0);
        do_op(8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b1, 8'hFE, 1'b1, 1'b0);
        do_op(8'h3C, 8'h5A, 1'b0, 8'hE2, 1'b1, 1'b0);
        do_op(8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0);
        do_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0);
        do_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        chk("cell_idle", {28'd0, cell_a, cell_b, cell_cin, cell_en}, 32'd0);

        // 4: start while busy is ignored
        dc0 = done_count;
        do_op(8'h5A, 8'h3C, 1'b1, 8'h96, 1'b0, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        chk("ignored_start_done_count", done_count - dc0, 1);
        chk("ignored_start_result", {24'd0, result}, 32'h96);

        // 5: reset in the middle of a run
        @(posedge clk); #1;
        a = 8'hFF; b = 8'hFF; op = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_result", {24'd0, result}, 32'd0);
        chk("midrst_cout", {31'd0, cout}, 32'd0);
        dc0 = done_count;
        repeat (12) @(posedge clk);
        #1;
        chk("midrst_no_done", done_count - dc0, 0);
        do_op(8'h12, 8'h34, 1'b1, 8'h46, 1'b0, 1'b0);

        // 6: start held high gives back-to-back runs
        @(posedge clk); #1;
        a = 8'h5A; b = 8'h3C; op = 1'b1; start = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 8'h96});
        k = 0;
        n = 0;
        while (n < 3 && k < 100) begin
            @(posedge clk); #1;
            k++;
            if (done) begin
                t[n] = k;
                n++;
            end
        end
        start = 1'b0;
        chk("b2b_runs", n, 3);
        if (n == 3) begin
            chk("b2b_gap1", t[1] - t[0], W + 2);
            chk("b2b_gap2", t[2] - t[1], W + 2);
        end
        repeat (15) @(posedge clk);
        #1;
        chk("b2b_idle", {31'd0, busy}, 32'd0);
        chk("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
